// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, FSM states,
// ALU function codes, instruction field positions and the opcode decoder.
package cpu_ctrl_pkg;

  // Instruction field bit positions
  localparam int OPC_HI = 19;
  localparam int OPC_LO = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 14;
  localparam int RS_HI  = 13;
  localparam int RS_LO  = 12;
  localparam int RT_HI  = 11;
  localparam int RT_LO  = 10;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Opcodes (A..E are undefined)
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_MUL   = 4'h6;
  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_MOVI  = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU function codes
  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_OR     = 3'd4;
  localparam logic [2:0] ALU_MUL    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       imm_sel;
    logic       rf_we;
    logic       legal;
  } dec_t;

  // Static per-opcode control. Memory ops address with the raw immediate,
  // so they pass operand B through with the immediate selected.
  function automatic dec_t decode_op(input logic [3:0] op);
    dec_t d;
    d = '{alu_op: ALU_PASS_B, imm_sel: 1'b0, rf_we: 1'b0, legal: 1'b1};
    case (op)
      OP_NOP:   ;
      OP_ADD:   begin d.alu_op = ALU_ADD; d.rf_we = 1'b1; end
      OP_SUB:   begin d.alu_op = ALU_SUB; d.rf_we = 1'b1; end
      OP_AND:   begin d.alu_op = ALU_AND; d.rf_we = 1'b1; end
      OP_OR:    begin d.alu_op = ALU_OR;  d.rf_we = 1'b1; end
      OP_ADDI:  begin d.alu_op = ALU_ADD; d.imm_sel = 1'b1; d.rf_we = 1'b1; end
      OP_MUL:   begin d.alu_op = ALU_MUL; d.rf_we = 1'b1; end
      OP_LOAD:  begin d.imm_sel = 1'b1; d.rf_we = 1'b1; end
      OP_STORE: begin d.imm_sel = 1'b1; end
      OP_MOVI:  begin d.imm_sel = 1'b1; d.rf_we = 1'b1; end
      OP_HALT:  ;
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// 4-bit load/decrement counter timing the WAIT state of the sequencer.
module seq_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_reg;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 4'd0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != 4'd0)) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 4-register 8-bit CPU. Latches each
// instruction, decodes it, sequences EXEC / WAIT / WB and releases the PC
// hold for exactly one cycle per retired instruction.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [19:0]      instruction,
  output logic             hold,
  output logic [1:0]       rf_raddr_a,
  output logic [1:0]       rf_raddr_b,
  output logic [1:0]       rf_waddr,
  output logic             rf_we,
  output logic [2:0]       alu_op,
  output logic             imm_sel,
  output logic             mem_re,
  output logic             mem_we,
  output logic             mul_start,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  // WAIT lasts LAT cycles: counter is loaded with LAT-1 and WB follows the
  // cycle on which it reads zero.
  localparam logic [3:0] MUL_WAIT = 4'(MUL_LAT - 1);
  localparam logic [3:0] MEM_WAIT = 4'(MEM_LAT - 1);

  state_t           state_reg, state_next;
  logic [19:0]      ir_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] retired_reg;

  logic [3:0] opcode;
  dec_t       dec;
  logic       wait_load;
  logic [3:0] wait_val;
  logic       wait_dec;
  logic       wait_zero;

  assign opcode = ir_reg[OPC_HI:OPC_LO];
  assign dec    = decode_op(opcode);

  // Decode outputs come only from the latched word, so they stay stable
  // from EXEC through WB regardless of what the PC presents.
  assign rf_raddr_a = ir_reg[RS_HI:RS_LO];
  assign rf_raddr_b = ir_reg[RT_HI:RT_LO];
  assign rf_waddr   = ir_reg[RD_HI:RD_LO];
  assign alu_op     = dec.alu_op;
  assign imm_sel    = dec.imm_sel;
  assign illegal    = illegal_reg;
  assign retired    = retired_reg;

  seq_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load),
    .load_val (wait_val),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_next = state_reg;
    hold       = 1'b1;
    rf_we      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mul_start  = 1'b0;
    busy       = 1'b1;
    halted     = 1'b0;
    wait_load  = 1'b0;
    wait_val   = 4'd0;
    wait_dec   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy       = 1'b0;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (instruction[OPC_HI:OPC_LO] == OP_HALT) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_WB;
        case (opcode)
          OP_MUL: begin
            mul_start  = 1'b1;
            wait_load  = 1'b1;
            wait_val   = MUL_WAIT;
            state_next = ST_WAIT;
          end
          OP_LOAD: begin
            mem_re     = 1'b1;
            wait_load  = 1'b1;
            wait_val   = MEM_WAIT;
            state_next = ST_WAIT;
          end
          OP_STORE: begin
            mem_we     = 1'b1;
            wait_load  = 1'b1;
            wait_val   = MEM_WAIT;
            state_next = ST_WAIT;
          end
          default: ;
        endcase
      end
      ST_WAIT: begin
        if (wait_zero) begin
          state_next = ST_WB;
        end else begin
          wait_dec = 1'b1;
        end
      end
      ST_WB: begin
        hold       = 1'b0;
        rf_we      = dec.rf_we;
        state_next = ST_DECODE;
      end
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Instruction latch, sticky illegal flag and retired counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_reg      <= 20'd0;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      if (state_reg == ST_DECODE) begin
        ir_reg <= instruction;
      end
      if ((state_reg == ST_EXEC) && !dec.legal) begin
        illegal_reg <= 1'b1;
      end
      if (state_reg == ST_WB) begin
        retired_reg <= retired_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed instructions push their
// hand-computed retirement record; a monitor pops and checks at each WB.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] instruction;
  logic        hold, rf_we, imm_sel, mem_re, mem_we, mul_start;
  logic        busy, halted, illegal;
  logic [1:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [2:0]  alu_op;
  logic [3:0]  retired;

  cpu_sequencer #(.MUL_LAT(4), .MEM_LAT(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .hold(hold),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .alu_op(alu_op), .imm_sel(imm_sel), .mem_re(mem_re),
    .mem_we(mem_we), .mul_start(mul_start), .busy(busy), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    len;
    int    we, waddr, ra, rb, alu, imm, mre, mwe, mst;
    int    ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_retired = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: accumulate per-instruction activity, compare at WB.
  int cyc = 0, n_re = 0, n_we = 0, n_mst = 0, n_early_we = 0;
  always @(negedge clk) begin
    if (reset || !busy) begin
      cyc = 0; n_re = 0; n_we = 0; n_mst = 0;
      if (!reset && rf_we) n_early_we++;
    end else begin
      cyc++;
      n_re  += int'(mem_re);
      n_we  += int'(mem_we);
      n_mst += int'(mul_start);
      if (hold && rf_we) n_early_we++;
      if (!hold) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, "_len"},     cyc, e.len);
          chk({e.name, "_rf_we"},   int'(rf_we), e.we);
          chk({e.name, "_waddr"},   int'(rf_waddr), e.waddr);
          chk({e.name, "_raddr_a"}, int'(rf_raddr_a), e.ra);
          chk({e.name, "_raddr_b"}, int'(rf_raddr_b), e.rb);
          chk({e.name, "_alu_op"},  int'(alu_op), e.alu);
          chk({e.name, "_imm_sel"}, int'(imm_sel), e.imm);
          chk({e.name, "_mem_re"},  n_re, e.mre);
          chk({e.name, "_mem_we"},  n_we, e.mwe);
          chk({e.name, "_mul_st"},  n_mst, e.mst);
          chk({e.name, "_retired"}, int'(retired), e.ret);
          $display("WB %s len=%0d rf_we=%0d waddr=%0d alu=%0d retired=%0d",
                   e.name, cyc, rf_we, rf_waddr, alu_op, retired);
        end
        cyc = 0; n_re = 0; n_we = 0; n_mst = 0;
      end
    end
  end

  // Issue one instruction and wait (bounded) for its WB cycle.
  task automatic run_instr(input logic [19:0] ins, input exp_t e);
    bit seen;
    e.ret = exp_retired;
    exp_q.push_back(e);
    exp_retired = (exp_retired + 1) % 16;
    instruction = ins;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy && !hold) seen = 1;
    end
    if (!seen) chk({e.name, "_wb_timeout"}, 0, 1);
  endtask

  function automatic exp_t mk(input string n, input int len, input int we,
                              input int wa, input int ra, input int rb,
                              input int alu, input int imm, input int mre,
                              input int mwe, input int mst);
    exp_t e;
    e = '{name: n, len: len, we: we, waddr: wa, ra: ra, rb: rb, alu: alu,
          imm: imm, mre: mre, mwe: mwe, mst: mst, ret: 0};
    return e;
  endfunction

  task automatic reset_dut();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold",    int'(hold), 1);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_halted",  int'(halted), 0);
    chk("rst_illegal", int'(illegal), 0);
    chk("rst_retired", int'(retired), 0);
    chk("rst_strobes", int'({rf_we, mem_re, mem_we, mul_start}), 0);
    exp_retired = 0;
    reset = 1'b0;
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    instruction = 20'h16C00;
    reset_dut();

    //                   name     len we wa ra rb alu imm re we mst
    run_instr(20'h16C00, mk("add",   3, 1, 1, 2, 3, 1, 0, 0, 0, 0));
    run_instr(20'h61800, mk("mul",   7, 1, 0, 1, 2, 5, 0, 0, 0, 1));
    run_instr(20'h80000, mk("store", 5, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    run_instr(20'hB0000, mk("ill_b", 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_instr(20'h5C0FF, mk("addi",  3, 1, 3, 0, 0, 1, 1, 0, 0, 0));
    chk("illegal_sticky", int'(illegal), 1);
    run_instr(20'h29000, mk("sub",   3, 1, 2, 1, 0, 2, 0, 0, 0, 0));
    run_instr(20'h3F400, mk("and",   3, 1, 3, 3, 1, 3, 0, 0, 0, 0));
    run_instr(20'h42800, mk("or",    3, 1, 0, 2, 2, 4, 0, 0, 0, 0));
    run_instr(20'h74010, mk("load",  5, 1, 1, 0, 0, 0, 1, 1, 0, 0));
    run_instr(20'h98080, mk("movi",  3, 1, 2, 0, 0, 0, 1, 0, 0, 0));
    run_instr(20'h00000, mk("nop",   3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("illegal_still", int'(illegal), 1);

    // Counter wrap: retired is 11 here; 5 more WBs pass 15 -> 0.
    for (int i = 0; i < 5; i++)
      run_instr(20'h00000, mk("nop_wrap", 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("retired_wrap", int'(retired), 0);

    // HALT: terminal, hold stuck high, not retired.
    instruction = 20'hF0000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk("halt_state", int'({halted, busy, hold}), 3'b101);
      @(negedge clk);
    end
    chk("halt_retired", int'(retired), 0);
    $display("HALT halted=%0d busy=%0d hold=%0d retired=%0d", halted, busy, hold, retired);

    instruction = 20'h61800;
    reset_dut();

    // Mid-MUL reset: abort in WAIT, no write strobe afterwards.
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mul_start) seen = 1;
    end
    if (!seen) chk("mul_start_timeout", 0, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_hold", int'(hold), 1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_we", int'(rf_we | mem_we), 0);
      @(negedge clk);
    end
    chk("abort_retired", int'(retired), 0);
    $display("ABORT busy=%0d hold=%0d retired=%0d", busy, hold, retired);

    chk("no_early_rf_we", n_early_we, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
